log_lut: RTL and testbench

Single-precision natural-logarithm unit computing ln(x) by exponent/mantissa decomposition and a 32-segment piecewise-linear LUT on the mantissa. It is the inverse companion of the LUT-based exponential unit in the same exp/log library. It uses fixed-point internal arithmetic and no vendor floating-point IP. A valid/ready handshake on input and output lets it sit directly on the float datapath next to the exponential unit.

---
 rtl/log_lut.sv | 195 +++++++++++++++++++
 tb/tb_log_lut.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_lut.sv
// Natural logarithm of a binary32 operand via exponent/mantissa split and a 32-segment linear LUT.
// Latency: result valid 4 edges after acceptance (DECODE, MAC, NORM, then DONE); one operand in flight.
// Backpressure: DONE holds result and flags unchanged until out_ready; in_ready is low until then.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/x_in  operand handshake (x_in is sampled once, on acceptance)
//   out_valid/out_ready     result handshake
//   result                  binary32 ln(x_in)
//   invalid                 operand was NaN or negative non-zero
//   div_zero                operand was +/-0 or subnormal (flushed to zero)
module log_lut (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        invalid,
  output logic        div_zero
);

  typedef enum logic [2:0] {IDLE, DECODE, MAC, NORM, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_INVALID, SP_DIVZ, SP_INF} special_t;

  // ln(2) in Q8.24
  localparam logic signed [31:0] LN2 = 32'sh00B1_7218;

  // ln(1 + k/32) in Q68.60, evaluated at elaboration time only.
  // Uses ln(a/b) = 2*atanh(z), z = (a-b)/(a+b) = k/(64+k) <= 1/3, so the
  // odd-power series converges fast; 40 terms is far below 2^-60.
  function automatic logic [127:0] ln_q60(input int k);
    logic [127:0] z;
    logic [127:0] z2;
    logic [127:0] p;
    logic [127:0] sum;
    z   = (128'(k) << 60) / 128'(64 + k);
    z2  = (z * z) >> 60;
    p   = z;
    sum = '0;
    for (int n = 0; n < 40; n++) begin
      sum = sum + p / 128'(2 * n + 1);
      p   = (p * z2) >> 60;
    end
    return sum << 1;
  endfunction

  // c0[i] = round(ln(1+i/32) * 2^24), packed 24 bits per entry
  function automatic logic [32*24-1:0] build_c0();
    logic [32*24-1:0] t;
    t = '0;
    for (int i = 0; i < 32; i++)
      t[i*24 +: 24] = 24'((ln_q60(i) + (128'd1 << 35)) >> 36);
    return t;
  endfunction

  // c1[i] = round(32 * (ln(1+(i+1)/32) - ln(1+i/32)) * 2^24), packed 25 bits per entry
  function automatic logic [32*25-1:0] build_c1();
    logic [32*25-1:0] t;
    t = '0;
    for (int i = 0; i < 32; i++)
      t[i*25 +: 25] = 25'((((ln_q60(i + 1) - ln_q60(i)) << 5) + (128'd1 << 35)) >> 36);
    return t;
  endfunction

  localparam logic [32*24-1:0] C0_TAB = build_c0();
  localparam logic [32*25-1:0] C1_TAB = build_c1();

  state_t state, state_nxt;

  logic [31:0]        x_q;
  logic signed [8:0]  e_q;
  logic [4:0]         idx_q;
  logic [17:0]        off_q;
  special_t           spec_q;
  logic signed [31:0] y_q;
  logic [31:0]        res_q;
  logic               inv_q;
  logic               dz_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == DONE);
    invalid   = (state == DONE) && inv_q;
    div_zero  = (state == DONE) && dz_q;
    result    = res_q;
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = DECODE;
      DECODE:  state_nxt = MAC;
      MAC:     state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- DECODE ----------------
  // Priority matters: NaN of either sign is invalid, any E=0 (including -0
  // and negative subnormals) is div_zero, then remaining negatives are invalid.
  special_t spec_dec;
  always_comb begin
    spec_dec = SP_NONE;
    if (x_q[30:23] == 8'hFF && x_q[22:0] != 23'd0) spec_dec = SP_INVALID;
    else if (x_q[30:23] == 8'h00)                  spec_dec = SP_DIVZ;
    else if (x_q[31])                              spec_dec = SP_INVALID;
    else if (x_q[30:23] == 8'hFF)                  spec_dec = SP_INF;
  end

  // ---------------- MAC ----------------
  logic [23:0]        c0_sel;
  logic [24:0]        c1_sel;
  logic [19:0]        interp;
  logic signed [31:0] e_term;
  logic signed [31:0] y_mac;
  always_comb begin
    c0_sel = C0_TAB[idx_q*24 +: 24];
    c1_sel = C1_TAB[idx_q*25 +: 25];
    // c1 * d / 2^23 = slope * (d / 2^18) in Q24; the 43-bit product is truncated
    interp = 20'((43'(c1_sel) * 43'(off_q)) >> 23);
    e_term = 32'(e_q) * LN2;
    y_mac  = e_term + $signed(32'(c0_sel)) + $signed(32'(interp));
  end

  // ---------------- NORM ----------------
  logic [31:0] mag;
  logic [4:0]  lead;
  logic [22:0] frac;
  logic [31:0] norm_val;
  logic [31:0] res_nxt;
  logic        inv_nxt;
  logic        dz_nxt;
  always_comb begin
    mag  = y_q[31] ? 32'(-y_q) : 32'(y_q);
    lead = '0;
    for (int b = 0; b < 31; b++)
      if (mag[b]) lead = 5'(b);
    // Shift the leading one to bit 31; the 23 bits below it are the mantissa.
    // Zero fill covers lead < 23, dropping the low bits truncates lead > 23.
    frac = 23'((mag << (5'd31 - lead)) >> 8);
    // value = mag * 2^-24, so the biased exponent is lead - 24 + 127
    norm_val = (y_q == 32'sd0) ? 32'd0 : {y_q[31], 8'(lead) + 8'd103, frac};

    res_nxt = norm_val;
    inv_nxt = 1'b0;
    dz_nxt  = 1'b0;
    case (spec_q)
      SP_INVALID: begin res_nxt = 32'h7FC0_0000; inv_nxt = 1'b1; end
      SP_DIVZ:    begin res_nxt = 32'hFF80_0000; dz_nxt  = 1'b1; end
      SP_INF:     res_nxt = 32'h7F80_0000;
      default:    ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q    <= '0;
      e_q    <= '0;
      idx_q  <= '0;
      off_q  <= '0;
      spec_q <= SP_NONE;
      y_q    <= '0;
      res_q  <= '0;
      inv_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) x_q <= x_in;
        DECODE: begin
          e_q    <= {1'b0, x_q[30:23]} - 9'd127;
          idx_q  <= x_q[22:18];
          off_q  <= x_q[17:0];
          spec_q <= spec_dec;
        end
        MAC:  y_q <= y_mac;
        NORM: begin
          res_q <= res_nxt;
          inv_q <= inv_nxt;
          dz_q  <= dz_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log_lut.sv
// Self-checking bench for log_lut: directed literals, backpressure, reset abort, random sweep.
// Latency: model expects out_valid 4 edges after the accepting edge.
// Backpressure: out_ready is dropped for 10 cycles to check result hold and input blocking.
module tb_log_lut;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        invalid;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam real TOL  = 1.0 / 4096.0;
  localparam real LN2R = 0.6931471805599453;

  log_lut dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .invalid  (invalid),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  // binary32 bits to real (results are never subnormal)
  function automatic real f2r(input logic [31:0] b);
    real m;
    if (b[30:23] == 8'd0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * $pow(2.0, real'(int'(b[30:23]) - 127));
    return b[31] ? -m : m;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_ln(input bit ok, input string name, input logic [31:0] x,
                        input logic [31:0] res, input real req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: x=%h result=%h (%f) required %f +/- 2^-12 flags 0 (t=%0t)",
               name, x, res, f2r(res), req, $time);
    end
  endtask

  // Reference: classify the operand; finite positive normals get (E-127)*ln2 + ln(mantissa).
  task automatic model(input logic [31:0] x, output bit sp, output logic [31:0] bits,
                       output bit inv, output bit dz, output real v);
    int ex;
    sp = 1'b1; bits = '0; inv = 1'b0; dz = 1'b0; v = 0.0;
    ex = int'(x[30:23]);
    if (ex == 255 && x[22:0] != 23'd0) begin bits = 32'h7FC00000; inv = 1'b1; end
    else if (ex == 0)                  begin bits = 32'hFF800000; dz  = 1'b1; end
    else if (x[31])                    begin bits = 32'h7FC00000; inv = 1'b1; end
    else if (ex == 255)                bits = 32'h7F800000;
    else begin
      sp = 1'b0;
      v  = real'(ex - 127) * LN2R + $ln(1.0 + real'(x[22:0]) / 8388608.0);
    end
  endtask

  // ---------------- compare process (every negedge) ----------------
  logic [31:0] pend_x = '0;
  logic [31:0] prev_res = '0;
  bit  busy = 0, held = 0, rst_prev = 0, btb = 0, have_last = 0;
  bit  prev_inv = 0, prev_dz = 0;
  int  acc_cyc = 0, last_acc = 0;

  always @(negedge clock) begin : cmp_proc
    bit          sp, mi, md;
    logic [31:0] mb;
    real         mv;
    if (reset) begin
      chk(!in_ready, "in_ready_during_reset", 32'(in_ready), 32'd0);
      if (rst_prev)
        chk(!out_valid && !invalid && !div_zero && result == 32'd0, "reset_state",
            {result[31:3], out_valid, invalid, div_zero}, 32'd0);
      busy = 0;
      held = 0;
    end else begin
      chk(in_ready == !busy, "in_ready", 32'(in_ready), 32'(!busy));
      chk(out_valid == (busy && (cyc - acc_cyc >= 4)), "out_valid_timing",
          32'(out_valid), 32'(busy && (cyc - acc_cyc >= 4)));
      chk(!(invalid && div_zero), "flags_exclusive", 32'({invalid, div_zero}), 32'd0);
      if (out_valid) begin
        if (busy) begin
          model(pend_x, sp, mb, mi, md, mv);
          if (sp)
            chk(result == mb && invalid == mi && div_zero == md, "special_result",
                {result[31:2], invalid, div_zero}, {mb[31:2], mi, md});
          else
            chk_ln(rabs(f2r(result) - mv) <= TOL && !invalid && !div_zero, "ln_accuracy",
                   pend_x, result, mv);
        end
        if (held)
          chk(result == prev_res && invalid == prev_inv && div_zero == prev_dz, "hold_stable",
              result, prev_res);
        prev_res = result;
        prev_inv = invalid;
        prev_dz  = div_zero;
        held     = !out_ready;
        if (out_ready) busy = 0;
      end else begin
        chk(!invalid && !div_zero, "flags_when_idle", 32'({invalid, div_zero}), 32'd0);
        held = 0;
      end
      if (in_valid && in_ready) begin
        if (btb && have_last)
          chk(cyc - last_acc == 5, "issue_interval", 32'(cyc - last_acc), 32'd5);
        have_last = 1;
        last_acc  = cyc;
        pend_x    = x_in;
        busy      = 1;
        acc_cyc   = cyc;
      end
    end
    rst_prev = reset;
  end

  // ---------------- driver helpers ----------------
  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic issue(input logic [31:0] x);
    int n;
    in_valid = 1'b1;
    x_in     = x;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk(1'b0, "accept_timeout", x, 32'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    x_in     = $urandom;
  endtask

  task automatic wait_result(output logic [31:0] r, output bit i, output bit d);
    int n;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) chk(1'b0, "result_timeout", 32'(out_valid), 32'd1);
    r = result;
    i = invalid;
    d = div_zero;
  endtask

  task automatic run_dir(input string name, input logic [31:0] x, input bit exact,
                         input logic [31:0] bits, input bit inv, input bit dz, input real val);
    logic [31:0] r;
    bit i, d;
    issue(x);
    wait_result(r, i, d);
    if (exact) chk(r == bits && i == inv && d == dz, name, {r[31:2], i, d}, {bits[31:2], inv, dz});
    else       chk_ln(rabs(f2r(r) - val) <= TOL && !i && !d, name, x, r, val);
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] r;
    bit i, d;
    int n;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    run_dir("one",        32'h3F800000, 1, 32'h00000000, 0, 0, 0.0);
    run_dir("e",          32'h402DF854, 0, 32'h0, 0, 0, 1.0);
    run_dir("half",       32'h3F000000, 0, 32'h0, 0, 0, -0.6931471806);
    run_dir("four",       32'h40800000, 0, 32'h0, 0, 0, 1.3862943611);
    run_dir("pos_zero",   32'h00000000, 1, 32'hFF800000, 0, 1, 0.0);
    run_dir("subnormal",  32'h00000001, 1, 32'hFF800000, 0, 1, 0.0);
    run_dir("neg_zero",   32'h80000000, 1, 32'hFF800000, 0, 1, 0.0);
    run_dir("neg_one",    32'hBF800000, 1, 32'h7FC00000, 1, 0, 0.0);
    run_dir("qnan",       32'h7FC00000, 1, 32'h7FC00000, 1, 0, 0.0);
    run_dir("neg_inf",    32'hFF800000, 1, 32'h7FC00000, 1, 0, 0.0);
    run_dir("pos_inf",    32'h7F800000, 1, 32'h7F800000, 0, 0, 0.0);
    run_dir("max_normal", 32'h7F7FFFFF, 0, 32'h0, 0, 0, 88.7228391117);
    run_dir("min_normal", 32'h00800000, 0, 32'h0, 0, 0, -87.3365447506);
    run_dir("below_one",  32'h3F7FFFFF, 0, 32'h0, 0, 0, -0.0000000596);

    // Backpressure: hold DONE for 10 cycles with a second operand waiting.
    out_ready = 1'b0;
    issue(32'h41200000);
    wait_result(r, i, d);
    chk_ln(rabs(f2r(r) - 2.302585093) <= TOL && !i && !d, "bp_first", 32'h41200000, r, 2.302585093);
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    x_in     = 32'h3E800000;
    repeat (10) begin
      @(negedge clock);
      chk(out_valid && result == r && !in_ready, "bp_hold", result, r);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    chk(!in_ready, "bp_ready_still_low", 32'(in_ready), 32'd0);
    @(negedge clock);
    chk(in_ready, "bp_ready_returns", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_result(r, i, d);
    chk_ln(rabs(f2r(r) - (-1.3862943611)) <= TOL && !i && !d, "bp_second", 32'h3E800000, r,
           -1.3862943611);
    @(posedge clock);
    #1;

    // Reset while in MAC aborts the operand.
    issue(32'h40400000);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    run_dir("after_reset", 32'h40000000, 0, 32'h0, 0, 0, 0.6931471806);

    // Back-to-back random positive normals.
    btb       = 1;
    have_last = 0;
    for (int k = 0; k < 10000; k++) begin
      in_valid = 1'b1;
      x_in     = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (!in_ready) chk(1'b0, "sweep_accept_timeout", x_in, 32'd0);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk(!busy, "sweep_drain", 32'(busy), 32'd0);
    btb = 0;

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
